// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner selection for a shared 8:1 data path.
// Picks one of eight requesters, drives the mux select, registers the chosen
// data word, and caps the length of each grant.
//
// Handshake: req[i] is a level request with no acknowledge. A grant lasts
// while req[sel] stays high, up to MAX_HOLD cycles (0 = unlimited). Every
// release goes through at least one IDLE cycle before the next grant.
// dout is meaningful only in cycles where dout_valid is high.
module mux_rr_arbiter #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     req,
    input  logic [8*W-1:0] din,
    output logic [7:0]     gnt,
    output logic [2:0]     sel,
    output logic [W-1:0]   dout,
    output logic           dout_valid,
    output logic           busy
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_CAP = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam bit HAS_CAP = (MAX_HOLD > 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             dv_q, dv_d;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [2:0]       cand;
    logic             release_w;

    // Round-robin search: first set request starting at ptr, wrapping mod 8.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A grant ends when the owner drops its request or the hold cap is reached.
    always_comb begin
        release_w = (state_q == S_GRANT) &&
                    (!req[sel_q] || (HAS_CAP && (cnt_q == CNT_CAP)));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including the grant bookkeeping registers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    sel_d   = win_idx;
                    gnt_d   = 8'b1 << win_idx;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (release_w) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = sel_q + 3'd1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Datapath next value: capture the owner's word while it is still requesting.
    always_comb begin
        dv_d   = (state_q == S_GRANT) && req[sel_q];
        dout_d = dout_q;
        if (dv_d) begin
            dout_d = din[sel_q*W +: W];
        end
    end

    // Grant bookkeeping and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            sel_q  <= '0;
            gnt_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            sel_q  <= sel_d;
            gnt_q  <= gnt_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    // Outputs: all driven straight from registers.
    always_comb begin
        gnt        = gnt_q;
        sel        = sel_q;
        dout       = dout_q;
        dout_valid = dv_q;
        busy       = (state_q == S_GRANT);
    end

endmodule
